mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single memory port of the priRV32 core between the instruction-fetch requester (I) and the load/store requester (D).
- Sits between the core's fetch/LSU stages and the memory slave that backs program and data storage.
- One outstanding transaction at a time. D has fixed priority, and an anti-starvation counter guarantees that I always makes progress.

Parameters:
- AW, 32, address width in bits.
- STARVE_MAX, 4, number of consecutive cycles I may lose arbitration before I is forced to win; range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  1  fetch request; held with i_addr stable until i_gnt.
- i_addr  in  AW  fetch address.
- i_gnt  out  1  fetch request accepted by the slave.
- i_rvalid  out  1  fetch read data valid.
- i_rdata  out  32  fetch read data.
- d_req  in  1  load/store request; held with its payload stable until d_gnt.
- d_we  in  1  1 = write.
- d_be  in  4  byte enables.
- d_addr  in  AW  data address.
- d_wdata  in  32  write data.
- d_gnt  out  1  load/store request accepted.
- d_rvalid  out  1  read data valid, or write acknowledge.
- d_rdata  out  32  load data.
- m_req  out  1  slave request.
- m_we  out  1  slave write enable.
- m_be  out  4  slave byte enables.
- m_addr  out  AW  slave address.
- m_wdata  out  32  slave write data.
- m_gnt  in  1  slave accepts request.
- m_rvalid  in  1  slave response; one per accepted request, for both reads and writes; arrives at least 1 cycle after m_gnt.
- m_rdata  in  32  slave read data.
- busy  out  1  a transaction is outstanding.

Behaviour:
- FSM states: IDLE, WAIT_I, WAIT_D. Reset state is IDLE, and starve_cnt resets to 0.
- Reset values: m_req, m_we, i_gnt, d_gnt, i_rvalid, d_rvalid and busy are 0. m_be, m_addr, m_wdata, i_rdata and d_rdata are 0.
- Winner selection in IDLE (combinational):
  - If d_req and i_req are both high and starve_cnt < STARVE_MAX, D wins.
  - If d_req and i_req are both high and starve_cnt == STARVE_MAX, I wins.
  - Otherwise, the single requester present wins.
  - With no requester, m_req = 0 and m_addr, m_wdata, m_be and m_we are 0.
- Request forwarding in IDLE:
  - m_req and the m_* payload come combinationally from the winner. For I: m_we = 0, m_be = 4'hF, m_wdata = 0.
  - The winner's gnt = m_gnt, in the same cycle and combinationally. The loser's gnt = 0.
- State transitions:
  - IDLE with m_req & m_gnt goes to WAIT_I or WAIT_D according to the winner.
  - IDLE with m_req & !m_gnt stays in IDLE and re-arbitrates the next cycle. The winner may change if starve_cnt reaches STARVE_MAX.
- WAIT_I / WAIT_D:
  - m_req = 0, busy = 1, both gnt = 0.
  - m_rvalid is routed to the owner only: i_rvalid = m_rvalid in WAIT_I, d_rvalid = m_rvalid in WAIT_D. The owner's rdata = m_rdata, and the other rdata = 0.
  - On m_rvalid, go to IDLE next cycle. New arbitration starts in that IDLE cycle, so peak throughput is one transaction per 2 cycles plus slave latency.
- starve_cnt (4 bits, registered):
  - Increments in any IDLE cycle where i_req = 1 and I is not the winner with m_gnt. It saturates at STARVE_MAX.
  - Clears when i_gnt = 1.
  - Holds in WAIT states. Clears when i_req = 0 in IDLE.
- Other rules:
  - m_rvalid in IDLE (stray response) is ignored: no rvalid is output and the state does not change.
  - Reset asserted mid-transaction returns immediately to IDLE with all outputs at their reset values. The outstanding response is discarded.
  - Simultaneous m_gnt and m_rvalid cannot occur in a WAIT state, because m_req = 0 there.
  - Requesters must not drop req before gnt. The arbiter does not need to check this.

Test Plan:
- Single fetch: i_req = 1, i_addr = 0x100, slave gnt at once, rvalid 2 cycles later with rdata = 0x00000013. Required: m_addr = 0x100, m_be = F, i_gnt = 1 for 1 cycle, then i_rvalid = 1 with i_rdata = 0x13, busy = 1 in between, d_rvalid stays 0.
- Store: d_req = 1, d_we = 1, d_be = 4'b0011, d_addr = 0x2000, d_wdata = 0xDEADBEEF. Required: m_* mirrors the D payload, d_gnt = 1, d_rvalid pulses once on the slave ack, i_* outputs stay 0.
- Contention and starvation, STARVE_MAX = 4: i_req and d_req held high continuously with a 1-cycle slave. Required: D wins the first 4 grants, then I wins the 5th, starve_cnt returns to 0, and the pattern repeats.
- Slave back-pressure: m_gnt = 0 for 3 cycles with only i_req high. Required: m_req is stable at 1 with m_addr stable, i_gnt = 0, the state stays IDLE, and the grant occurs on the cycle m_gnt = 1.
- Stray response plus reset: m_rvalid = 1 in IDLE gives no i_rvalid or d_rvalid. Separately, assert rst_n = 0 in WAIT_D, then release. Required: all outputs 0 asynchronously, a later m_rvalid is ignored, and the next i_req is granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester, memory-slave and status signals shared by the arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface mem_bus_arbiter_if #(
  parameter int AW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_rdata;

  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;

  logic          m_req;
  logic          m_we;
  logic [3:0]    m_be;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic          m_gnt;
  logic          m_rvalid;
  logic [31:0]   m_rdata;

  logic          busy;

  modport master (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_gnt, m_rvalid, m_rdata,
    output busy
  );

  modport slave (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_be, m_addr, m_wdata,
    output m_gnt, m_rvalid, m_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D) requesters.
// D has fixed priority; a starvation counter forces I to win eventually.
module mem_bus_arbiter #(
  parameter int AW         = 32,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_I,
    WAIT_D
  } state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e        state_q, state_d;
  logic [3:0]    starveCnt_q, starveCnt_d;
  logic          iWins, dWins;
  logic [AW-1:0] addrSel;

  always_comb begin
    iWins = 1'b0;
    dWins = 1'b0;
    if (bus.d_req && bus.i_req) begin
      if (starveCnt_q >= STARVE_LIM) iWins = 1'b1;
      else                           dWins = 1'b1;
    end else if (bus.d_req) begin
      dWins = 1'b1;
    end else if (bus.i_req) begin
      iWins = 1'b1;
    end
  end

  // Outputs are gated by rst_n so reset forces them to zero asynchronously
  always_comb begin
    state_d      = state_q;
    starveCnt_d  = starveCnt_q;
    addrSel      = '0;
    bus.m_req    = 1'b0;
    bus.m_we     = 1'b0;
    bus.m_be     = 4'h0;
    bus.m_wdata  = 32'h0;
    bus.i_gnt    = 1'b0;
    bus.d_gnt    = 1'b0;
    bus.i_rvalid = 1'b0;
    bus.d_rvalid = 1'b0;
    bus.i_rdata  = 32'h0;
    bus.d_rdata  = 32'h0;
    bus.busy     = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (dWins) begin
            bus.m_req   = 1'b1;
            bus.m_we    = bus.d_we;
            bus.m_be    = bus.d_be;
            addrSel     = bus.d_addr;
            bus.m_wdata = bus.d_wdata;
            bus.d_gnt   = bus.m_gnt;
          end else if (iWins) begin
            bus.m_req   = 1'b1;
            bus.m_be    = 4'hF;
            addrSel     = bus.i_addr;
            bus.i_gnt   = bus.m_gnt;
          end
          if ((dWins || iWins) && bus.m_gnt) begin
            state_d = iWins ? WAIT_I : WAIT_D;
          end
          if (!bus.i_req) begin
            starveCnt_d = 4'h0;
          end else if (iWins && bus.m_gnt) begin
            starveCnt_d = 4'h0;
          end else if (starveCnt_q < STARVE_LIM) begin
            starveCnt_d = starveCnt_q + 4'h1;
          end
        end
        WAIT_I: begin
          bus.busy     = 1'b1;
          bus.i_rvalid = bus.m_rvalid;
          bus.i_rdata  = bus.m_rdata;
          if (bus.m_rvalid) state_d = IDLE;
        end
        WAIT_D: begin
          bus.busy     = 1'b1;
          bus.d_rvalid = bus.m_rvalid;
          bus.d_rdata  = bus.m_rdata;
          if (bus.m_rvalid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    bus.m_addr = addrSel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starveCnt_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      starveCnt_q <= starveCnt_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: fetch, store, contention,
// back-pressure, stray response and mid-transaction reset.
module tb_mem_bus_arbiter;

  logic clk;
  logic rst_n;
  int   testCount;
  int   failCount;

  mem_bus_arbiter_if #(.AW(32)) bus ();

  mem_bus_arbiter #(.AW(32), .STARVE_MAX(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                               input logic dReq, input logic dWe,
                               input logic [3:0] dBe, input logic [31:0] dAddr,
                               input logic [31:0] dWdata, input logic mGnt,
                               input logic mRvalid, input logic [31:0] mRdata);
    bus.i_req    = iReq;
    bus.i_addr   = iAddr;
    bus.d_req    = dReq;
    bus.d_we     = dWe;
    bus.d_be     = dBe;
    bus.d_addr   = dAddr;
    bus.d_wdata  = dWdata;
    bus.m_gnt    = mGnt;
    bus.m_rvalid = mRvalid;
    bus.m_rdata  = mRdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [9:0] iWinPattern;
    logic       expI;
    testCount   = 0;
    failCount   = 0;
    iWinPattern = 10'b1000010000;
    rst_n       = 1'b0;
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    #10;
    checkOutput("rst_m_req", {31'b0, bus.m_req}, 32'h0);
    checkOutput("rst_i_gnt", {31'b0, bus.i_gnt}, 32'h0);
    checkOutput("rst_busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("rst_m_addr", bus.m_addr, 32'h0);
    checkOutput("rst_m_be", {28'b0, bus.m_be}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single fetch with two-cycle response latency
    tick();
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("f_m_req", {31'b0, bus.m_req}, 32'h1);
    checkOutput("f_m_addr", bus.m_addr, 32'h100);
    checkOutput("f_m_be", {28'b0, bus.m_be}, 32'hF);
    checkOutput("f_m_we", {31'b0, bus.m_we}, 32'h0);
    checkOutput("f_i_gnt", {31'b0, bus.i_gnt}, 32'h1);
    checkOutput("f_d_gnt", {31'b0, bus.d_gnt}, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("f_busy1", {31'b0, bus.busy}, 32'h1);
    checkOutput("f_i_gnt_off", {31'b0, bus.i_gnt}, 32'h0);
    checkOutput("f_m_req_off", {31'b0, bus.m_req}, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("f_busy2", {31'b0, bus.busy}, 32'h1);
    checkOutput("f_i_rvalid_early", {31'b0, bus.i_rvalid}, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h13);
    checkOutput("f_i_rvalid", {31'b0, bus.i_rvalid}, 32'h1);
    checkOutput("f_i_rdata", bus.i_rdata, 32'h13);
    checkOutput("f_d_rvalid", {31'b0, bus.d_rvalid}, 32'h0);
    checkOutput("f_d_rdata", bus.d_rdata, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("f_busy_done", {31'b0, bus.busy}, 32'h0);

    // Store
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h2000, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    checkOutput("s_m_req", {31'b0, bus.m_req}, 32'h1);
    checkOutput("s_m_we", {31'b0, bus.m_we}, 32'h1);
    checkOutput("s_m_be", {28'b0, bus.m_be}, 32'h3);
    checkOutput("s_m_addr", bus.m_addr, 32'h2000);
    checkOutput("s_m_wdata", bus.m_wdata, 32'hDEADBEEF);
    checkOutput("s_d_gnt", {31'b0, bus.d_gnt}, 32'h1);
    checkOutput("s_i_gnt", {31'b0, bus.i_gnt}, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h55);
    checkOutput("s_d_rvalid", {31'b0, bus.d_rvalid}, 32'h1);
    checkOutput("s_i_rvalid", {31'b0, bus.i_rvalid}, 32'h0);
    checkOutput("s_i_rdata", bus.i_rdata, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("s_d_rvalid_off", {31'b0, bus.d_rvalid}, 32'h0);

    // Contention: four D grants then one I grant, repeated
    for (int k = 0; k < 10; k++) begin
      expI = iWinPattern[k];
      tick();
      applyStimulus(1'b1, 32'h300, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput($sformatf("c%0d_i_gnt", k), {31'b0, bus.i_gnt}, {31'b0, expI});
      checkOutput($sformatf("c%0d_d_gnt", k), {31'b0, bus.d_gnt}, {31'b0, ~expI});
      checkOutput($sformatf("c%0d_m_addr", k), bus.m_addr, expI ? 32'h300 : 32'h400);
      tick();
      applyStimulus(1'b1, 32'h300, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0, 1'b0, 1'b1, 32'(k));
      checkOutput($sformatf("c%0d_i_rvalid", k), {31'b0, bus.i_rvalid}, {31'b0, expI});
      checkOutput($sformatf("c%0d_d_rvalid", k), {31'b0, bus.d_rvalid}, {31'b0, ~expI});
    end
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Slave back-pressure on a lone fetch
    for (int k = 0; k < 3; k++) begin
      tick();
      applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("bp%0d_m_req", k), {31'b0, bus.m_req}, 32'h1);
      checkOutput($sformatf("bp%0d_m_addr", k), bus.m_addr, 32'h500);
      checkOutput($sformatf("bp%0d_i_gnt", k), {31'b0, bus.i_gnt}, 32'h0);
      checkOutput($sformatf("bp%0d_busy", k), {31'b0, bus.busy}, 32'h0);
    end
    tick();
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("bp_i_gnt", {31'b0, bus.i_gnt}, 32'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("bp_busy", {31'b0, bus.busy}, 32'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hABCD);
    checkOutput("bp_i_rvalid", {31'b0, bus.i_rvalid}, 32'h1);
    checkOutput("bp_i_rdata", bus.i_rdata, 32'hABCD);
    tick();

    // Stray response in IDLE
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hAA);
    checkOutput("st_i_rvalid", {31'b0, bus.i_rvalid}, 32'h0);
    checkOutput("st_d_rvalid", {31'b0, bus.d_rvalid}, 32'h0);
    checkOutput("st_i_rdata", bus.i_rdata, 32'h0);
    checkOutput("st_busy", {31'b0, bus.busy}, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("st_busy_after", {31'b0, bus.busy}, 32'h0);

    // Reset while waiting on a load response
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("r_d_gnt", {31'b0, bus.d_gnt}, 32'h1);
    tick();
    applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h99);
    checkOutput("r_busy_pre", {31'b0, bus.busy}, 32'h1);
    checkOutput("r_d_rvalid_pre", {31'b0, bus.d_rvalid}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("r_busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("r_m_req", {31'b0, bus.m_req}, 32'h0);
    checkOutput("r_m_addr", bus.m_addr, 32'h0);
    checkOutput("r_m_be", {28'b0, bus.m_be}, 32'h0);
    checkOutput("r_d_rvalid", {31'b0, bus.d_rvalid}, 32'h0);
    checkOutput("r_d_rdata", bus.d_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h77);
    checkOutput("r_late_d_rvalid", {31'b0, bus.d_rvalid}, 32'h0);
    checkOutput("r_late_i_rvalid", {31'b0, bus.i_rvalid}, 32'h0);
    checkOutput("r_late_busy", {31'b0, bus.busy}, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h800, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("r_next_i_gnt", {31'b0, bus.i_gnt}, 32'h1);
    checkOutput("r_next_m_addr", bus.m_addr, 32'h800);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("r_next_busy", {31'b0, bus.busy}, 32'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234);
    checkOutput("r_next_i_rvalid", {31'b0, bus.i_rvalid}, 32'h1);
    checkOutput("r_next_i_rdata", bus.i_rdata, 32'h1234);
    tick();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
